// File: rtl/tdc_pulse_gen.sv
// Digital-to-time converter: a {coarse, phase} delay word places a pulse edge at
// pll_clk[0] cycle resolution plus a sub-period offset chosen from the PLL phases.
`timescale 1ns/1ps
module tdc_pulse_gen #(
  parameter int unsigned PHASES = 16,
  parameter int unsigned PH_W   = 4,
  parameter int unsigned CW     = 24,
  parameter int unsigned WW     = 8
) (
  input  logic [PHASES-1:0]    pll_clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CW+PH_W-1:0]   cfg_delay,
  input  logic [WW-1:0]        cfg_width,
  input  logic                 trig,
  output logic                 pulse_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_COUNT, S_HIGH, S_TAIL, S_DONE
  } state_t;

  typedef struct packed {
    logic [CW-1:0]   coarse;
    logic [PH_W-1:0] phase;
    logic [WW-1:0]   width;
  } cfg_t;

  state_t            state, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [PH_W-1:0]   sel, sel_d;
  logic [WW-1:0]     run_w, run_w_d;
  logic              win_c, win_q;
  logic              cfg_xfer_c, ovr_c;
  logic              clk0;
  logic [PHASES-1:0] ph_q;

  assign clk0       = pll_clk[0];
  assign cfg_xfer_c = cfg_valid & cfg_ready;

  // Control-domain state, counters and registered outputs
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cfg_q       <= '0;
      sel         <= '0;
      run_w       <= '0;
      win_q       <= 1'b0;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cfg_q       <= cfg_d;
      sel         <= sel_d;
      run_w       <= run_w_d;
      win_q       <= win_c;
      cfg_ready   <= (state_d == S_IDLE) || (state_d == S_ARMED);
      busy        <= (state_d != S_IDLE) && (state_d != S_ARMED);
      done        <= (state_d == S_DONE);
      err_overrun <= ovr_c;
    end
  end

  // Next state; the single counter serves coarse delay, pulse width and tail
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cfg_d   = cfg_q;
    sel_d   = sel;
    run_w_d = run_w;
    win_c   = 1'b0;
    ovr_c   = trig && (state != S_ARMED);

    if (cfg_xfer_c) begin
      cfg_d.coarse = cfg_delay[CW+PH_W-1:PH_W];
      cfg_d.phase  = cfg_delay[PH_W-1:0];
      cfg_d.width  = (cfg_width == '0) ? WW'(1) : cfg_width;
    end

    case (state)
      S_IDLE: begin
        if (cfg_xfer_c) state_d = S_ARMED;
      end
      S_ARMED: begin
        // Latch from the old config so a same-cycle update only affects the next shot
        if (trig) begin
          state_d = S_COUNT;
          cnt_d   = cfg_q.coarse;
          sel_d   = cfg_q.phase;
          run_w_d = cfg_q.width;
        end
      end
      S_COUNT: begin
        if (cnt == '0) begin
          state_d = S_HIGH;
          cnt_d   = CW'(run_w) - CW'(1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_HIGH: begin
        win_c = 1'b1;
        if (cnt == '0) begin
          state_d = S_TAIL;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_TAIL: begin
        if (cnt == '0) state_d = S_DONE;
        else           cnt_d   = cnt - CW'(1);
      end
      S_DONE: begin
        state_d = S_ARMED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // One capture flop per phase; only the selected one ever toggles.
  // Phase 0 shares win_q's clock edge, so it samples win one stage earlier to
  // keep the same two-cycle latency as every other phase.
  for (genvar i = 0; i < int'(PHASES); i++) begin : g_ph
    logic cap_c;
    logic ph_bit;
    if (i == 0) begin : g_p0
      assign cap_c = win_c & (sel == PH_W'(0));
    end else begin : g_pn
      assign cap_c = win_q & (sel == PH_W'(i));
    end
    always_ff @(posedge pll_clk[i] or negedge rst) begin
      if (!rst) ph_bit <= 1'b0;
      else      ph_bit <= cap_c;
    end
    assign ph_q[i] = ph_bit;
  end

  assign pulse_out = |ph_q;

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Bench for tdc_pulse_gen: expected pulse edges are queued at trigger time and
// compared against measured pulse_out rise time and width.
`timescale 1ns/1ps
module tb_tdc_pulse_gen;

  localparam int unsigned PHASES = 16;
  localparam int unsigned PH_W   = 4;
  localparam int unsigned CW     = 24;
  localparam int unsigned WW     = 8;
  localparam int          T_PS    = 6400;
  localparam int          STEP_PS = 400;

  logic [PHASES-1:0]  pll_clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CW+PH_W-1:0] cfg_delay;
  logic [WW-1:0]      cfg_width;
  logic               trig;
  logic               pulse_out;
  logic               busy;
  logic               done;
  logic               err_overrun;

  typedef struct {
    int rise_ps;
    int width_ps;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_c, m_p, m_w;
  bit   m_armed;
  int   r_c, r_w;
  int   cyc;
  int   t0_ps;
  int   rise_ps;
  int   cur_w;
  bit   have_rise;
  bit   skip_w;

  tdc_pulse_gen #(
    .PHASES(PHASES), .PH_W(PH_W), .CW(CW), .WW(WW)
  ) dut (
    .pll_clk    (pll_clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .trig       (trig),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .err_overrun(err_overrun)
  );

  // 6.4 ns period, phase g lags phase 0 by g*0.4 ns
  for (genvar g = 0; g < int'(PHASES); g++) begin : g_clk
    logic ck;
    initial begin
      ck = 1'b0;
      #(0.4 * g);
      forever #3.2 ck = ~ck;
    end
    assign pll_clk[g] = ck;
  end

  function automatic int now_ps();
    return int'($realtime * 1000.0);
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $realtime);
    end
  endtask

  always @(posedge pulse_out) begin
    exp_t e;
    rise_ps = now_ps();
    if (exp_q.size() == 0) begin
      have_rise = 1'b0;
      check_eq("spurious_rise", rise_ps, -1);
    end else begin
      e         = exp_q.pop_front();
      cur_w     = e.width_ps;
      have_rise = 1'b1;
      check_eq("rise_time", rise_ps, e.rise_ps);
    end
  end

  always @(negedge pulse_out) begin
    if (have_rise) begin
      have_rise = 1'b0;
      if (!skip_w) check_eq("pulse_width", now_ps() - rise_ps, cur_w);
    end
  end

  task automatic tick();
    @(posedge pll_clk[0]);
    #1;
    cyc++;
  endtask

  task automatic send_cfg(input int c, input int p, input int w);
    bit ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_delay = {CW'(c), PH_W'(p)};
    cfg_width = WW'(w);
    for (int k = 0; k < 40 && !ok; k++) begin
      if (cfg_ready) ok = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    check_eq("cfg_accept", int'(ok), 1);
    m_c     = c;
    m_p     = p;
    m_w     = (w == 0) ? 1 : w;
    m_armed = 1'b1;
  endtask

  task automatic fire();
    trig = 1'b1;
    @(posedge pll_clk[0]);
    t0_ps = now_ps();
    if (m_armed) begin
      r_c = m_c;
      r_w = m_w;
      exp_q.push_back('{t0_ps + (m_c + 2) * T_PS + m_p * STEP_PS, m_w * T_PS});
    end
    #1;
    trig = 1'b0;
    cyc  = 0;
  endtask

  task automatic wait_done(input bit trig_on_done);
    int lim = r_c + r_w + 10;
    int busy_low = 0;
    while (!done && cyc < lim) begin
      if (!busy) busy_low++;
      tick();
    end
    check_eq("done_seen", int'(done), 1);
    check_eq("done_cycle", cyc, r_c + r_w + 3);
    check_eq("busy_gap", busy_low, 0);
    check_eq("busy_at_done", int'(busy), 1);
    if (trig_on_done) trig = 1'b1;
    tick();
    trig = 1'b0;
    check_eq("done_one_cycle", int'(done), 0);
    check_eq("busy_after", int'(busy), 0);
    check_eq("ready_after", int'(cfg_ready), 1);
    if (trig_on_done) check_eq("ovr_on_done", int'(err_overrun), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_valid = 1'b0;
    cfg_delay = '0;
    cfg_width = '0;
    trig      = 1'b0;
    m_armed   = 1'b0;
    m_c = 0; m_p = 0; m_w = 0; r_c = 0; r_w = 0;
    have_rise = 1'b0;
    skip_w    = 1'b0;
    rst = 1'b1;
    #0.5 rst = 1'b0;
    #0.5;
    check_eq("rst_cfg_ready", int'(cfg_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_ovr", int'(err_overrun), 0);
    check_eq("rst_pulse", int'(pulse_out), 0);
    repeat (2) @(posedge pll_clk[0]);
    #1 rst = 1'b1;
    tick();

    // Trigger with no config is an overrun and produces nothing
    fire();
    check_eq("ovr_idle", int'(err_overrun), 1);
    check_eq("busy_idle", int'(busy), 0);
    tick();
    check_eq("ovr_idle_clear", int'(err_overrun), 0);

    send_cfg(10, 0, 4);
    fire();
    check_eq("ready_busy", int'(cfg_ready), 0);
    wait_done(1'b0);

    for (int p = 0; p < 16; p++) begin
      send_cfg(10, p, 4);
      fire();
      wait_done(1'b0);
    end

    send_cfg(0, 15, 0);
    fire();
    wait_done(1'b0);

    // Stray trigger mid-count while a new config is offered
    send_cfg(10, 3, 4);
    fire();
    repeat (4) tick();
    trig      = 1'b1;
    cfg_valid = 1'b1;
    cfg_delay = {CW'(2), PH_W'(9)};
    cfg_width = WW'(7);
    check_eq("ready_in_count", int'(cfg_ready), 0);
    tick();
    trig = 1'b0;
    check_eq("ovr_count", int'(err_overrun), 1);
    check_eq("ready_in_count2", int'(cfg_ready), 0);
    tick();
    cfg_valid = 1'b0;
    check_eq("ovr_count_clear", int'(err_overrun), 0);
    wait_done(1'b0);

    // Trigger on done is an overrun; trigger one cycle later fires
    fire();
    wait_done(1'b1);
    fire();
    wait_done(1'b0);

    // Config and trigger together: this shot uses the old config
    cfg_valid = 1'b1;
    cfg_delay = {CW'(6), PH_W'(9)};
    cfg_width = WW'(3);
    fire();
    cfg_valid = 1'b0;
    m_c = 6; m_p = 9; m_w = 3;
    wait_done(1'b0);
    fire();
    wait_done(1'b0);

    // Asynchronous reset in the middle of a pulse
    send_cfg(3, 5, 8);
    fire();
    for (int k = 0; k < 20 && !pulse_out; k++) tick();
    check_eq("pulse_high", int'(pulse_out), 1);
    #1.5;
    skip_w = 1'b1;
    rst    = 1'b0;
    #0.1;
    check_eq("rst_pulse_async", int'(pulse_out), 0);
    check_eq("rst_mid_ready", int'(cfg_ready), 1);
    check_eq("rst_mid_busy", int'(busy), 0);
    exp_q.delete();
    m_armed = 1'b0;
    m_c = 0; m_p = 0; m_w = 0;
    @(posedge pll_clk[0]);
    #1 rst = 1'b1;
    skip_w = 1'b0;
    tick();
    fire();
    check_eq("ovr_after_rst", int'(err_overrun), 1);
    tick();
    check_eq("idle_after_rst", int'(busy), 0);

    repeat (5) tick();
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("pulse_idle", int'(pulse_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
